// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
//
// Writer side of the 80x60 text-mode character buffer scanned by the VGA
// display controller. Takes a byte stream (printable ASCII plus CR, LF, BS
// and FF) over a valid/ready handshake. Drives the write port of the
// character RAM and keeps track of a cursor. A cell lives at
// address row*COLS + col, which is the mapping the display side reads.
//
// Configuration macro: VGA_TEXT_WRAP_CLEAR_EN
//   defined   : every row advance (LF or wrap after column 79) clears the new
//               row with FILL_CHAR. That takes 80 write cycles, and ready is
//               low during them.
//   undefined : a row advance only moves the cursor. The old content stays.
//
// Ports
//   clk_i         in   1   system clock
//   rst_i         in   1   synchronous, active-high reset (screen not cleared)
//   char_i        in   8   input byte
//   char_valid_i  in   1   char_i valid
//   char_ready_o  out  1   high only when idle; transfer = valid & ready
//   ram_addr_o    out  13  char RAM write address
//   ram_data_o    out  8   char RAM write data
//   ram_we_o      out  1   char RAM write strobe, one cell per cycle
//   cursor_x_o    out  7   current column, 0..COLS-1
//   cursor_y_o    out  6   current row, 0..ROWS-1
//   busy_o        out  1   high while clearing a line or the screen
// ---------------------------------------------------------------------------
module vga_text_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 60,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic [12:0] ram_addr_o,
    output logic [7:0]  ram_data_o,
    output logic        ram_we_o,
    output logic [6:0]  cursor_x_o,
    output logic [5:0]  cursor_y_o,
    output logic        busy_o
);

    localparam int CELLS = COLS * ROWS;

`ifdef VGA_TEXT_WRAP_CLEAR_EN
    localparam bit WRAP_CLEAR = 1'b1;
`else
    localparam bit WRAP_CLEAR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR_LINE,
        S_CLR_SCREEN
    } state_t;

    state_t      state, state_n;
    logic [12:0] cnt, cnt_n;
    logic [6:0]  col_n;
    logic [5:0]  row_n;
    logic        we_n;
    logic [12:0] addr_n;
    logic [7:0]  data_n;

    logic [12:0] row_base;
    logic [5:0]  row_inc;

    assign row_base     = 13'(cursor_y_o) * 13'(COLS);
    assign row_inc      = (cursor_y_o == 6'(ROWS - 1)) ? 6'd0 : cursor_y_o + 6'd1;
    assign char_ready_o = (state == S_IDLE);
    assign busy_o       = (state == S_CLR_LINE) || (state == S_CLR_SCREEN);

    // Next-state logic. All RAM port and cursor outputs are registered, so a
    // write shows up the cycle after its transfer. The cursor moves in that
    // same cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_n = state;
        cnt_n   = cnt;
        col_n   = cursor_x_o;
        row_n   = cursor_y_o;
        we_n    = 1'b0;
        addr_n  = ram_addr_o;
        data_n  = ram_data_o;

        case (state)
            S_IDLE: begin
                if (char_valid_i) begin
                    if (char_i >= 8'h20 && char_i <= 8'h7E) begin
                        we_n   = 1'b1;
                        addr_n = row_base + 13'(cursor_x_o);
                        data_n = char_i;
                        if (cursor_x_o == 7'(COLS - 1)) begin
                            col_n = 7'd0;
                            row_n = row_inc;
                            if (WRAP_CLEAR) begin
                                state_n = S_CLR_LINE;
                                cnt_n   = 13'd0;
                            end
                        end else begin
                            col_n = cursor_x_o + 7'd1;
                        end
                    end else begin
                        case (char_i)
                            8'h0D: col_n = 7'd0;
                            8'h0A: begin
                                col_n = 7'd0;
                                row_n = row_inc;
                                if (WRAP_CLEAR) begin
                                    state_n = S_CLR_LINE;
                                    cnt_n   = 13'd0;
                                end
                            end
                            8'h08: begin
                                // Backspace at column 0 does nothing. It never
                                // moves back to the previous row.
                                if (cursor_x_o != 7'd0) begin
                                    col_n  = cursor_x_o - 7'd1;
                                    we_n   = 1'b1;
                                    addr_n = row_base + 13'(cursor_x_o) - 13'd1;
                                    data_n = FILL_CHAR;
                                end
                            end
                            8'h0C: begin
                                state_n = S_CLR_SCREEN;
                                cnt_n   = 13'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // The cursor already holds the new row, so row_base points at the
            // line that has to be cleared.
            S_CLR_LINE: begin
                we_n   = 1'b1;
                addr_n = row_base + cnt;
                data_n = FILL_CHAR;
                cnt_n  = cnt + 13'd1;
                if (cnt == 13'(COLS - 1)) begin
                    state_n = S_IDLE;
                end
            end

            S_CLR_SCREEN: begin
                we_n   = 1'b1;
                addr_n = cnt;
                data_n = FILL_CHAR;
                cnt_n  = cnt + 13'd1;
                if (cnt == 13'(CELLS - 1)) begin
                    state_n = S_IDLE;
                    col_n   = 7'd0;
                    row_n   = 6'd0;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: registers use non-blocking assignments, so every flop samples
        // the values from before the edge, whatever the statement order.
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= 13'd0;
            cursor_x_o <= 7'd0;
            cursor_y_o <= 6'd0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= 13'd0;
            ram_data_o <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cursor_x_o <= col_n;
            cursor_y_o <= row_n;
            ram_we_o   <= we_n;
            ram_addr_o <= addr_n;
            ram_data_o <= data_n;
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_writer
//
// Self-checking bench for vga_text_writer. A reference model turns each
// accepted byte into a queue of expected RAM writes and a new cursor
// position. It uses plain column/row arithmetic on the screen rules. A
// monitor on the falling edge matches every RAM write against the queue, in
// order. Directed scenarios cover the boundary cases, and a random byte
// stream follows them. Build with +define+VGA_TEXT_WRAP_CLEAR_EN to check the
// line-clearing variant.
// ---------------------------------------------------------------------------
module tb_vga_text_writer;

`ifdef VGA_TEXT_WRAP_CLEAR_EN
    localparam bit WRAP_CLEAR = 1'b1;
`else
    localparam bit WRAP_CLEAR = 1'b0;
`endif

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic [12:0] ram_addr_o;
    logic [7:0]  ram_data_o;
    logic        ram_we_o;
    logic [6:0]  cursor_x_o;
    logic [5:0]  cursor_y_o;
    logic        busy_o;

    vga_text_writer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .ram_we_o     (ram_we_o),
        .cursor_x_o   (cursor_x_o),
        .cursor_y_o   (cursor_y_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         mcol = 0;
    int         mrow = 0;
    int         exp_addr[$];
    logic [7:0] exp_data[$];
    bit         mon_en = 1'b0;

    task automatic push_write(input int a, input logic [7:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic advance_row();
        mrow = (mrow + 1) % ROWS;
        if (WRAP_CLEAR)
            for (int i = 0; i < COLS; i++) push_write(mrow * COLS + i, 8'h20);
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_write(mrow * COLS + mcol, c);
            if (mcol == COLS - 1) begin
                mcol = 0;
                advance_row();
            end else begin
                mcol++;
            end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            mcol = 0;
            advance_row();
        end else if (c == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                push_write(mrow * COLS + mcol, 8'h20);
            end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) push_write(i, 8'h20);
            mcol = 0;
            mrow = 0;
        end
    endtask

    // ---------------- write monitor ----------------
    always @(negedge clk_i) begin
        int         a;
        logic [7:0] d;
        if (mon_en) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 32'(ram_we_o), 32'd0);
            end else if (ram_we_o) begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                check("we_addr", 32'(ram_addr_o), 32'(a));
                check("we_data", 32'(ram_data_o), 32'(d));
            end
            if (ram_we_o) check("we_addr_range", 32'(ram_addr_o < 13'(CELLS)), 32'd1);
        end
    end

    // ---------------- driver tasks (called on a falling edge) ----------------
    task automatic send(input logic [7:0] c, output int waited);
        waited       = 0;
        char_i       = c;
        char_valid_i = 1'b1;
        while (!char_ready_o && waited < 6000) begin
            @(negedge clk_i);
            waited++;
        end
        check("ready_wait", 32'(char_ready_o), 32'd1);
        model_apply(c);
        @(negedge clk_i);
        char_valid_i = 1'b0;
    endtask

    task automatic send1(input logic [7:0] c);
        int w;
        send(c, w);
    endtask

    task automatic sync_idle(input string tag);
        int guard = 0;
        while ((exp_addr.size() != 0 || !char_ready_o) && guard < 10000) begin
            @(negedge clk_i);
            guard++;
        end
        check({tag, "_drained"}, 32'(guard < 10000), 32'd1);
        check({tag, "_x"}, 32'(cursor_x_o), 32'(mcol));
        check({tag, "_y"}, 32'(cursor_y_o), 32'(mrow));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_i  = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        mcol  = 0;
        mrow  = 0;
        exp_addr.delete();
        exp_data.delete();
        mon_en = 1'b1;
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    function automatic logic [7:0] rand_other();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
               b == 8'h0C || b == 8'h0D);
        return b;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int guard;
        int r;
        rst_i        = 1'b1;
        char_i       = 8'h00;
        char_valid_i = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Reset values
        check("rst_we",    32'(ram_we_o),     32'd0);
        check("rst_addr",  32'(ram_addr_o),   32'd0);
        check("rst_data",  32'(ram_data_o),   32'd0);
        check("rst_x",     32'(cursor_x_o),   32'd0);
        check("rst_y",     32'(cursor_y_o),   32'd0);
        check("rst_ready", 32'(char_ready_o), 32'd1);
        check("rst_busy",  32'(busy_o),       32'd0);

        // 1: single character
        send1(8'h41);
        sync_idle("t1");

        // 2: back-to-back characters with no ready wait
        do_reset();
        send(8'h48, w);
        check("b2b_wait_h", 32'(w), 32'd0);
        send(8'h69, w);
        check("b2b_wait_i", 32'(w), 32'd0);
        check("b2b_ready", 32'(char_ready_o), 32'd1);
        sync_idle("t2");

        // 3: wrap at column 79 on row 2
        send1(8'h0A);
        send1(8'h0A);
        while (mcol != COLS - 1) send1(rand_print());
        sync_idle("t3_pre");
        send1(8'h41);
        check("t3_ready", 32'(char_ready_o), 32'(!WRAP_CLEAR));
        check("t3_busy",  32'(busy_o),       32'(WRAP_CLEAR));
        sync_idle("t3");

        // 4: LF from row 59 wraps to row 0
        while (mrow != ROWS - 1) send1(8'h0A);
        for (int i = 0; i < 5; i++) send1(rand_print());
        sync_idle("t4_pre");
        send1(8'h0A);
        check("t4_ready", 32'(char_ready_o), 32'(!WRAP_CLEAR));
        sync_idle("t4");

        // 5: backspace mid-row and at column 0
        send1(8'h0A);
        for (int i = 0; i < 3; i++) send1(rand_print());
        sync_idle("t5_pre");
        send1(8'h08);
        sync_idle("t5_bs");
        send1(8'h0D);
        send1(8'h08);
        sync_idle("t5_bs0");

        // 6: form feed clears the whole screen
        send1(8'h41);
        send1(8'h0C);
        check("t6_busy", 32'(busy_o), 32'd1);
        sync_idle("t6");
        check("t6_ready", 32'(char_ready_o), 32'd1);

        // 6b: reset during a screen clear, at write 1000
        mon_en       = 1'b0;
        char_i       = 8'h0C;
        char_valid_i = 1'b1;
        @(negedge clk_i);
        char_valid_i = 1'b0;
        n     = ram_we_o ? 1 : 0;
        guard = 0;
        while (n < 1000 && guard < 2000) begin
            @(negedge clk_i);
            guard++;
            if (ram_we_o) n++;
        end
        check("t6b_addr999", 32'(ram_addr_o), 32'd999);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t6b_we",    32'(ram_we_o),     32'd0);
        check("t6b_x",     32'(cursor_x_o),   32'd0);
        check("t6b_y",     32'(cursor_y_o),   32'd0);
        check("t6b_ready", 32'(char_ready_o), 32'd1);
        check("t6b_busy",  32'(busy_o),       32'd0);
        rst_i = 1'b0;
        mcol  = 0;
        mrow  = 0;
        exp_addr.delete();
        exp_data.delete();
        mon_en = 1'b1;
        repeat (5) @(negedge clk_i);
        sync_idle("t6b");

        // Random byte stream against the model
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      send1(rand_print());
            else if (r < 77) send1(8'h0A);
            else if (r < 83) send1(8'h0D);
            else if (r < 93) send1(8'h08);
            else             send1(rand_other());
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            if (i % 25 == 24) sync_idle("rnd");
        end
        sync_idle("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
